sized_fifo_level: RTL

Circular-buffer FIFO, the parametrised successor to the team's shift-register sized FIFO. Adds read/write pointers with wrap-around for arbitrary depth, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and a pipeline mode that accepts enqueue while full if a dequeue fires in the same cycle. Sits between producer/consumer stages wherever elastic buffering with level feedback is needed, e.g. credit-based flow control or burst gating.

---
 rtl/sized_fifo_level_if.sv | 33 +++
 rtl/sized_fifo_level.sv | 76 +++++++
 2 files changed

// File: rtl/sized_fifo_level_if.sv
// Enqueue/dequeue handshake bundle for sized_fifo_level.
// master = producer/consumer side, slave = FIFO side.
interface sized_fifo_level_if #(
   parameter int width = 128
);
   logic             in_enq__ENA;
   logic [width-1:0] in_enq_v;
   logic             in_enq__RDY;
   logic             out_deq__ENA;
   logic             out_deq__RDY;
   logic [width-1:0] out_first;
   logic             out_first__RDY;

   modport master (
      output in_enq__ENA,
      output in_enq_v,
      output out_deq__ENA,
      input  in_enq__RDY,
      input  out_deq__RDY,
      input  out_first,
      input  out_first__RDY
   );

   modport slave (
      input  in_enq__ENA,
      input  in_enq_v,
      input  out_deq__ENA,
      output in_enq__RDY,
      output out_deq__RDY,
      output out_first,
      output out_first__RDY
   );
endinterface

// File: rtl/sized_fifo_level.sv
// Circular-buffer FIFO with occupancy count, level flags,
// synchronous flush and optional full-cycle pipelining.
module sized_fifo_level #(
   parameter int depth            = 20,
   parameter int width            = 128,
   parameter int bypass           = 0,
   parameter int almostFullLevel  = depth - 1,
   parameter int almostEmptyLevel = 1,
   localparam int CW = $clog2(depth + 1)
) (
   input  logic                CLK,
   input  logic                nRST,
   sized_fifo_level_if.slave   io,
   input  logic                clear__ENA,
   output logic                clear__RDY,
   output logic [CW-1:0]       count,
   output logic                almostFull,
   output logic                almostEmpty
);

   localparam int PW = (depth > 2) ? $clog2(depth) : 1;
   localparam logic [CW-1:0] FULL = CW'(depth);
   localparam logic [PW-1:0] LAST = PW'(depth - 1);

   logic [width-1:0] mem [depth];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic             empty;
   logic             full;
   logic             enq_fire;
   logic             deq_fire;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] bump(
      input logic [PW-1:0] p
   );
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign empty = (count == '0);
   assign full  = (count == FULL);

   assign io.in_enq__RDY =
      !full || (bypass != 0 && io.out_deq__ENA);
   assign io.out_deq__RDY   = !empty;
   assign io.out_first__RDY = !empty;
   assign io.out_first      = empty ? '0 : mem[rp];

   assign enq_fire = io.in_enq__ENA && io.in_enq__RDY;
   assign deq_fire = io.out_deq__ENA && !empty;

   assign clear__RDY  = 1'b1;
   assign almostFull  = 32'(count) >= almostFullLevel;
   assign almostEmpty = 32'(count) <= almostEmptyLevel;

   always_ff @(posedge CLK) begin
      if (!nRST || clear__ENA) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (enq_fire) wp <= bump(wp);
         if (deq_fire) rp <= bump(rp);
         if (enq_fire && !deq_fire)
            count <= count + 1'b1;
         else if (deq_fire && !enq_fire)
            count <= count - 1'b1;
      end
   end

   // Full + both firing: wp == rp, so the write refills the vacated slot.
   always_ff @(posedge CLK) begin
      if (enq_fire) mem[wp] <= io.in_enq_v;
   end

endmodule
